// File: rtl/mem_port_arbiter_pkg.sv
// Purpose : shared types and constants for the IF/MEM memory port arbiter.
// Latency : n/a (types and constants only).
// Backpr. : n/a. Stop/NoStop are also used by the pipeline stall controller.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_t;

  // Stall-request levels toward the pipeline stall controller.
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Latency counter width; covers MEM_LAT up to 4 with headroom.
  localparam int CNT_W = 3;

  function automatic owner_t other_owner(input owner_t o);
    return (o == DATA) ? INST : DATA;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Purpose : counts memory read latency from the issue cycle up to MEM_LAT.
// Latency : done is high in the MEM_LAT-th WAIT cycle after start.
// Backpr. : none; free-running once started, cleared by rst.
// Ports   : clk, rst (sync, active-high), start (issue cycle),
//           run (waiting for data), done (one-cycle pulse at the latency match).
module mem_lat_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic done
);

  logic [CNT_W-1:0] cnt;

  assign done = run && (cnt == CNT_W'(MEM_LAT));

  // start loads 1 so the first WAIT cycle already counts as one latency cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_W'(1);
    end else if (done) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported sync memory between IF and MEM pipeline paths.
// Latency : request seen in IDLE -> ack after MEM_LAT+2 cycles; one idle bubble between accesses.
// Backpr. : requesters hold req until ack; stallreq_* stay high from request up to the ack cycle.
// Ports   : clk, rst (sync, active-high); IF side inst_req/addr/flush -> inst_ack/rdata;
//           MEM side data_req/we/addr/wdata -> data_ack/rdata; memory side mem_en/we/addr/wdata,
//           mem_rdata; stall requests stallreq_for_if / stallreq_for_mem.
// Option  : ARB_ROUND_ROBIN_EN alternates grants on simultaneous requests (DATA first after
//           reset); without it DATA always wins because it belongs to the older instruction.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_flush,
  output logic                inst_ack,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_ack,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq_for_if,
  output logic                stallreq_for_mem
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t state;
  owner_t     owner;
  owner_t     grant;
  logic       inst_ack_q;
  logic       flush_pend;
  logic       flush_hit;
  logic       lat_done;

  mem_lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (state == ISSUE),
    .run   (state == WAIT),
    .done  (lat_done)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // Owner served most recently; reset value INST hands the first tie to DATA.
  owner_t last_owner;

  always_comb begin
    grant = INST;
    if (inst_req && data_req) begin
      grant = other_owner(last_owner);
    end else if (data_req) begin
      grant = DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= INST;
    end else if (state == IDLE && (inst_req || data_req)) begin
      last_owner <= grant;
    end
  end
`else
  always_comb begin
    grant = data_req ? DATA : INST;
  end
`endif

  // A flush only matters while an IF access is actually in flight.
  assign flush_hit = inst_flush && (owner == INST);

  // A flush landing in the RESP cycle itself still has to kill the pulse.
  assign inst_ack = inst_ack_q && !inst_flush;

  assign stallreq_for_if  = (inst_req && !inst_ack) ? Stop : NoStop;
  assign stallreq_for_mem = (data_req && !data_ack) ? Stop : NoStop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= INST;
      mem_en     <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_ack_q <= 1'b0;
      data_ack   <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
      flush_pend <= 1'b0;
    end else begin
      inst_ack_q <= 1'b0;
      data_ack   <= 1'b0;
      case (state)
        IDLE: begin
          flush_pend <= 1'b0;
          if (inst_req || data_req) begin
            state  <= ISSUE;
            owner  <= grant;
            mem_en <= 1'b1;
            if (grant == DATA) begin
              mem_we    <= data_we;
              mem_addr  <= data_addr;
              mem_wdata <= data_wdata;
            end else begin
              mem_we    <= '0;
              mem_addr  <= inst_addr;
              mem_wdata <= '0;
            end
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= '0;
          state  <= WAIT;
          if (flush_hit) begin
            flush_pend <= 1'b1;
          end
        end
        WAIT: begin
          if (flush_hit) begin
            flush_pend <= 1'b1;
          end
          // Data arrives in this cycle; register it so it is valid with the ack in RESP.
          if (lat_done) begin
            state <= RESP;
            if (owner == DATA) begin
              data_rdata <= mem_rdata;
              data_ack   <= 1'b1;
            end else begin
              inst_rdata <= mem_rdata;
              inst_ack_q <= !flush_pend && !inst_flush;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed self-checking bench for mem_port_arbiter (MEM_LAT=1 and MEM_LAT=4 instances).
// Latency : n/a.
// Backpr. : n/a.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst4;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_flush;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;

  logic        a_inst_ack, a_data_ack, a_mem_en, a_stall_if, a_stall_mem;
  logic [31:0] a_inst_rdata, a_data_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_we;
  logic        b_inst_ack, b_data_ack, b_mem_en, b_stall_if, b_stall_mem;
  logic [31:0] b_inst_rdata, b_data_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_we;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
    .inst_ack(a_inst_ack), .inst_rdata(a_inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(a_data_ack), .data_rdata(a_data_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata),
    .stallreq_for_if(a_stall_if), .stallreq_for_mem(a_stall_mem)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst4),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
    .inst_ack(b_inst_ack), .inst_rdata(b_inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(b_data_ack), .data_rdata(b_data_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata),
    .stallreq_for_if(b_stall_if), .stallreq_for_mem(b_stall_mem)
  );

  // Memory contents seen by reads; anything off the read slot returns 0x0BAD0BAD.
  function automatic logic [31:0] rd_word(input logic [31:0] addr);
    case (addr)
      32'h10:  return 32'hAABBCCDD;
      32'h20:  return 32'h55667788;
      32'h100: return 32'h11112222;
      default: return addr ^ 32'hA5A50000;
    endcase
  endfunction

  logic [31:0] pipe_a [4];
  logic [31:0] pipe_b [4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      pipe_a[i] = 32'h0BAD0BAD;
      pipe_b[i] = 32'h0BAD0BAD;
    end
  end

  always @(posedge clk) begin
    pipe_a[0] <= a_mem_en ? rd_word(a_mem_addr) : 32'h0BAD0BAD;
    pipe_b[0] <= b_mem_en ? rd_word(b_mem_addr) : 32'h0BAD0BAD;
    for (int i = 1; i < 4; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end

  assign a_mem_rdata = pipe_a[0];
  assign b_mem_rdata = pipe_b[3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] grants [$];
  logic [31:0] g;
  logic        rr;

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst = 1'b1; rst4 = 1'b1;
    inst_req = 1'b0; inst_addr = '0; inst_flush = 1'b0;
    data_req = 1'b0; data_we = '0; data_addr = '0; data_wdata = '0;
    repeat (3) cyc();

    // Reset state
    chk("rst_inst_ack",   a_inst_ack, 0);
    chk("rst_data_ack",   a_data_ack, 0);
    chk("rst_mem_en",     a_mem_en, 0);
    chk("rst_mem_we",     a_mem_we, 0);
    chk("rst_mem_addr",   a_mem_addr, 0);
    chk("rst_mem_wdata",  a_mem_wdata, 0);
    chk("rst_inst_rdata", a_inst_rdata, 0);
    chk("rst_data_rdata", a_data_rdata, 0);
    chk("rst_state",      u_dut.state, 2'd0);
    rst = 1'b0;
    cyc();

    // Fetch with MEM_LAT=1
    inst_req = 1'b1; inst_addr = 32'h10; #1;
    chk("t1_stall_c0", a_stall_if, 1);
    chk("t1_en_c0", a_mem_en, 0);
    cyc();
    chk("t1_en_c1", a_mem_en, 1);
    chk("t1_addr_c1", a_mem_addr, 32'h10);
    chk("t1_we_c1", a_mem_we, 0);
    chk("t1_stall_c1", a_stall_if, 1);
    cyc();
    chk("t1_memrd_c2", a_mem_rdata, 32'hAABBCCDD);
    chk("t1_en_c2", a_mem_en, 0);
    chk("t1_ack_c2", a_inst_ack, 0);
    chk("t1_stall_c2", a_stall_if, 1);
    cyc();
    chk("t1_ack_c3", a_inst_ack, 1);
    chk("t1_rdata_c3", a_inst_rdata, 32'hAABBCCDD);
    chk("t1_stall_c3", a_stall_if, 0);
    inst_req = 1'b0;
    cyc();
    chk("t1_ack_c4", a_inst_ack, 0);
    chk("t1_rdata_hold", a_inst_rdata, 32'hAABBCCDD);

    // Simultaneous requests: DATA first
    cyc();
    inst_req = 1'b1; inst_addr = 32'h40;
    data_req = 1'b1; data_we = 4'b0000; data_addr = 32'h100; #1;
    chk("t2_stall_if_c0", a_stall_if, 1);
    chk("t2_stall_mem_c0", a_stall_mem, 1);
    cyc();
    chk("t2_en_c1", a_mem_en, 1);
    chk("t2_addr_c1", a_mem_addr, 32'h100);
    cyc();
    cyc();
    chk("t2_dack_c3", a_data_ack, 1);
    chk("t2_drdata_c3", a_data_rdata, 32'h11112222);
    chk("t2_iack_c3", a_inst_ack, 0);
    chk("t2_stall_mem_c3", a_stall_mem, 0);
    chk("t2_stall_if_c3", a_stall_if, 1);
    data_req = 1'b0;
    cyc();
    chk("t2_en_c4", a_mem_en, 0);
    chk("t2_dack_c4", a_data_ack, 0);
    cyc();
    chk("t2_en_c5", a_mem_en, 1);
    chk("t2_addr_c5", a_mem_addr, 32'h40);
    cyc();
    chk("t2_iack_c6", a_inst_ack, 0);
    cyc();
    chk("t2_iack_c7", a_inst_ack, 1);
    chk("t2_irdata_c7", a_inst_rdata, 32'hA5A50040);
    inst_req = 1'b0;

    // Store
    cyc();
    data_req = 1'b1; data_we = 4'b0011; data_addr = 32'h200; data_wdata = 32'h12345678;
    cyc();
    chk("t3_en_c1", a_mem_en, 1);
    chk("t3_we_c1", a_mem_we, 4'b0011);
    chk("t3_wdata_c1", a_mem_wdata, 32'h12345678);
    chk("t3_addr_c1", a_mem_addr, 32'h200);
    cyc();
    chk("t3_dack_c2", a_data_ack, 0);
    cyc();
    chk("t3_dack_c3", a_data_ack, 1);
    data_req = 1'b0; data_we = 4'b0000;

    // Flush during WAIT, then a fresh fetch with a flush seen in IDLE
    cyc();
    inst_req = 1'b1; inst_addr = 32'h30;
    cyc();
    chk("t4_en_c1", a_mem_en, 1);
    cyc();
    chk("t4_state_wait", u_dut.state, 2'd2);
    inst_flush = 1'b1; inst_req = 1'b0;
    cyc();
    inst_flush = 1'b0; #1;
    chk("t4_noack_c3", a_inst_ack, 0);
    chk("t4_rdata_c3", a_inst_rdata, 32'hA5A50030);
    cyc();
    chk("t4_state_idle", u_dut.state, 2'd0);
    chk("t4_noack_c4", a_inst_ack, 0);
    inst_req = 1'b1; inst_addr = 32'h20; inst_flush = 1'b1;
    cyc();
    inst_flush = 1'b0;
    chk("t4_en_c5", a_mem_en, 1);
    chk("t4_addr_c5", a_mem_addr, 32'h20);
    cyc();
    cyc();
    chk("t4_ack_c7", a_inst_ack, 1);
    chk("t4_rdata_c7", a_inst_rdata, 32'h55667788);
    inst_req = 1'b0;

    // Flush arriving in the RESP cycle itself
    cyc();
    inst_req = 1'b1; inst_addr = 32'h10;
    cyc();
    cyc();
    cyc();
    inst_flush = 1'b1; inst_req = 1'b0; #1;
    chk("t4b_ack_resp", a_inst_ack, 0);
    chk("t4b_rdata_resp", a_inst_rdata, 32'hAABBCCDD);
    cyc();
    inst_flush = 1'b0; #1;
    chk("t4b_state_idle", u_dut.state, 2'd0);
    chk("t4b_ack_after", a_inst_ack, 0);

    // MEM_LAT=4 instance: full fetch, then reset mid-WAIT
    cyc();
    rst = 1'b1; rst4 = 1'b0;
    cyc();
    chk("t5_b_idle_ack", b_inst_ack, 0);
    inst_req = 1'b1; inst_addr = 32'h10;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("t5_lat4_ack", b_inst_ack, (k == 6));
      if (k == 1) chk("t5_lat4_en", b_mem_en, 1);
    end
    chk("t5_lat4_rdata", b_inst_rdata, 32'hAABBCCDD);
    inst_req = 1'b0;
    cyc();
    inst_req = 1'b1; inst_addr = 32'h20;
    cyc();
    chk("t5_en_c1", b_mem_en, 1);
    cyc();
    chk("t5_state_wait", u_dut4.state, 2'd2);
    rst4 = 1'b1; inst_req = 1'b0;
    cyc();
    rst4 = 1'b0;
    chk("t5_state_idle", u_dut4.state, 2'd0);
    chk("t5_en_rst", b_mem_en, 0);
    chk("t5_addr_rst", b_mem_addr, 0);
    chk("t5_ack_rst", b_inst_ack, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t5_no_late_ack", b_inst_ack, 0);
      chk("t5_no_late_rdata", b_inst_rdata, 0);
    end

    // Both requesters held continuously
    cyc();
    rst = 1'b0; rst4 = 1'b1;
    cyc();
    inst_req = 1'b1; inst_addr = 32'h40;
    data_req = 1'b1; data_addr = 32'h100; data_we = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (a_mem_en) grants.push_back(a_mem_addr);
    end
    inst_req = 1'b0; data_req = 1'b0;
    chk("t6_grant_count", grants.size(), 4);
    for (int i = 0; i < 4; i++) begin
      g = (i < grants.size()) ? grants[i] : 32'hFFFFFFFF;
      chk("t6_grant_order", g, (rr && (i % 2 == 1)) ? 32'h40 : 32'h100);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the instruction-fetch path (IF) and the data-access path (MEM) of the 5-stage pipeline.
- Sequences each access through a small FSM, returns read data with a one-cycle ack pulse, and raises stall requests toward the pipeline stall controller while a requester is waiting.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- MEM_LAT, 1, memory read latency in cycles after the mem_en cycle; legal range 1..4.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset: synchronous, active-high.
- inst_req  input  1  IF request; level, held until inst_ack.
- inst_addr  input  ADDR_W  IF address.
- inst_flush  input  1  branch flush; suppresses the ack of an in-flight IF access.
- inst_ack  output  1  one-cycle completion pulse to IF.
- inst_rdata  output  DATA_W  fetched word; valid when inst_ack=1 and held until the next inst_ack.
- data_req  input  1  MEM request; level, held until data_ack.
- data_we  input  DATA_W/8  byte write enables; 0 means read.
- data_addr  input  ADDR_W  MEM address.
- data_wdata  input  DATA_W  store data.
- data_ack  output  1  one-cycle completion pulse to MEM.
- data_rdata  output  DATA_W  load word; valid when data_ack=1 and held until the next data_ack.
- mem_en  output  1  memory access strobe, one cycle per transaction.
- mem_we  output  DATA_W/8  memory byte enables.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- stallreq_for_if  output  1  inst_req & ~inst_ack (combinational).
- stallreq_for_mem  output  1  data_req & ~data_ack (combinational).

Behaviour:
- Reset values:
  - State IDLE.
  - All acks, mem_en and mem_we are 0.
  - mem_addr, mem_wdata, inst_rdata and data_rdata are 0.
  - Latency counter is 0.
  - Flush-pending flag is 0.
- States:
  - IDLE: no access in flight.
  - ISSUE: mem_en driven for one cycle; owner is INST or DATA.
  - WAIT: counting MEM_LAT.
  - RESP: ack pulse.
- IDLE → ISSUE on the cycle after any request is seen (registered outputs).
  - Both requests pending: DATA wins, because it belongs to the older instruction.
  - The address, wdata and we of the owner are captured on that edge.
  - INST owner forces mem_we=0.
- ISSUE: mem_en=1 for exactly one cycle, then go to WAIT with counter=1.
- WAIT: counter increments each cycle; when it equals MEM_LAT, go to RESP.
- RESP:
  - Capture mem_rdata into the owner's rdata register and pulse the owner's ack.
  - Writes pulse the ack in RESP too, so latency is uniform.
  - Next state IDLE.
  - Latency from request seen in IDLE to ack = MEM_LAT+2 cycles.
  - One idle bubble separates back-to-back transactions.
- Stall requests are high from the request cycle up to, but not including, the ack cycle.
- inst_flush:
  - Asserted while owner=INST and in ISSUE, WAIT or RESP: the memory access still completes and the rdata register updates, but inst_ack is suppressed.
  - inst_flush in IDLE has no effect; the next inst_req is a fresh fetch.
- A requester dropping its req mid-transaction is ignored: the transaction completes and the ack still pulses.
- Changing the address mid-transaction has no effect, because it was captured at issue.
- Reset mid-transaction: return to IDLE immediately; a late mem_rdata is ignored; no ack is produced.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: a 1-bit last-owner register is kept. On simultaneous requests, grant goes to the requester not served last. After reset, DATA has priority first.
- Not defined: fixed DATA-over-INST priority.

Decomposition:
- Shared package/defines header holds:
  - State encodings: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - Owner encoding: INST=1'b0, DATA=1'b1.
  - `Stop`/`NoStop` stall-request constants, shared with the pipeline controller.
- One natural sub-module, mem_lat_counter: counts from the issue cycle to the MEM_LAT match and produces a done pulse.

Test Plan:
- Read-only fetch, MEM_LAT=1: inst_req, inst_addr=0x00000010 at cycle 0. Required response: mem_en at cycle 1; mem_rdata=0xAABBCCDD at cycle 2; inst_ack and inst_rdata=0xAABBCCDD at cycle 3; stallreq_for_if high in cycles 0-2.
- Simultaneous requests: inst_req and data_req (load, addr 0x100) at cycle 0. Required response: DATA issues first, data_ack at cycle 3; INST issues at cycle 5, inst_ack at cycle 7.
- Store: data_we=4'b0011, addr 0x200, wdata 0x12345678. Required response: mem_we=4'b0011, mem_wdata=0x12345678 with mem_en; data_ack arrives MEM_LAT+2 cycles after the request.
- Flush: inst_flush pulsed during WAIT. Required response: no inst_ack; the state returns to IDLE; a subsequent inst_req to 0x20 is acked normally.
- Reset mid-WAIT with MEM_LAT=4. Required response: the next cycle is IDLE, outputs are 0, and no ack appears.
- ARB_ROUND_ROBIN_EN, both requesters held continuously. Required response: grants alternate DATA, INST, DATA, INST.
